// File: rtl/pulse_gen_if.sv
// Control/status bundle for the pulse generator: the requester drives start/stop
// and the burst configuration; the generator returns the waveform and its status.
interface pulse_gen_if #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] delay_cyc;
  logic [CNT_W-1:0] high_cyc;
  logic [CNT_W-1:0] low_cyc;
  logic [NUM_W-1:0] pulse_num;
  logic             a;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [NUM_W-1:0] pulse_cnt;

  modport master (
    output start, stop, delay_cyc, high_cyc, low_cyc, pulse_num,
    input  a, busy, done, aborted, pulse_cnt
  );

  modport slave (
    input  start, stop, delay_cyc, high_cyc, low_cyc, pulse_num,
    output a, busy, done, aborted, pulse_cnt
  );
endinterface

// File: rtl/pulse_gen.sv
// Programmable single/burst pulse generator: start delay, high width, low width
// and pulse count; the waveform a is a plain register set only in HIGH.
module pulse_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  pulse_gen_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] HIGH  = 2'd2;
  localparam logic [1:0] LOW   = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_low;
  logic [NUM_W-1:0] r_num;
  logic [NUM_W-1:0] r_pulse_cnt;
  logic             r_a;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  logic [CNT_W-1:0] w_high_ld;
  logic [CNT_W-1:0] w_low_ld;
  logic [NUM_W-1:0] w_num_ld;
  logic [NUM_W-1:0] w_pc_inc;
  logic             w_accept;

  // Zero-valued widths and counts behave as one.
  assign w_high_ld = (bus.high_cyc  == '0) ? CNT_W'(1) : bus.high_cyc;
  assign w_low_ld  = (bus.low_cyc   == '0) ? CNT_W'(1) : bus.low_cyc;
  assign w_num_ld  = (bus.pulse_num == '0) ? NUM_W'(1) : bus.pulse_num;
  assign w_pc_inc  = (&r_pulse_cnt) ? r_pulse_cnt : r_pulse_cnt + NUM_W'(1);
  assign w_accept  = bus.start && !bus.stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_high      <= '0;
      r_low       <= '0;
      r_num       <= '0;
      r_pulse_cnt <= '0;
      r_a         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_high <= w_high_ld;
            r_low  <= w_low_ld;
            r_num  <= w_num_ld;
            r_busy <= 1'b1;
            if (bus.delay_cyc == '0) begin
              // Clear-then-increment collapses to 1 when HIGH is entered directly.
              r_state     <= HIGH;
              r_a         <= 1'b1;
              r_cnt       <= w_high_ld - CNT_W'(1);
              r_pulse_cnt <= NUM_W'(1);
            end else begin
              r_state     <= DELAY;
              r_cnt       <= bus.delay_cyc - CNT_W'(1);
              r_pulse_cnt <= '0;
            end
          end
        end
        DELAY: begin
          if (bus.stop) begin
            r_state   <= IDLE;
            r_a       <= 1'b0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
          end else if (r_cnt == '0) begin
            r_state     <= HIGH;
            r_a         <= 1'b1;
            r_cnt       <= r_high - CNT_W'(1);
            r_pulse_cnt <= w_pc_inc;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        HIGH: begin
          if (bus.stop) begin
            r_state   <= IDLE;
            r_a       <= 1'b0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
          end else if (r_cnt == '0) begin
            r_a <= 1'b0;
            if (r_pulse_cnt == r_num) begin
              // Last pulse: no trailing low phase.
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= LOW;
              r_cnt   <= r_low - CNT_W'(1);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        LOW: begin
          if (bus.stop) begin
            r_state   <= IDLE;
            r_a       <= 1'b0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
          end else if (r_cnt == '0) begin
            r_state     <= HIGH;
            r_a         <= 1'b1;
            r_cnt       <= r_high - CNT_W'(1);
            r_pulse_cnt <= w_pc_inc;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.a         = r_a;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.aborted   = r_aborted;
  assign bus.pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: per-cycle waveform/status checks after each start.
module tb_pulse_gen;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  pulse_gen_if #(.CNT_W(16), .NUM_W(8)) bus ();

  pulse_gen #(.CNT_W(16), .NUM_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present config and raise start just after a falling edge; next rising edge accepts.
  task automatic launch(input int d, input int h, input int l, input int n);
    @(negedge clk);
    bus.delay_cyc = 16'(d);
    bus.high_cyc  = 16'(h);
    bus.low_cyc   = 16'(l);
    bus.pulse_num = 8'(n);
    bus.start     = 1'b1;
  endtask

  // Sample i is taken at the falling edge after accepting edge k+i; MSB = sample 0.
  task automatic run_seq(input string tag, input int n,
                         input logic [31:0] ea, input logic [31:0] ed,
                         input logic [31:0] eab, input logic [31:0] eb,
                         input int poke_on, input int poke_off, input int stop_idx);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
      end
      chk($sformatf("%s a[%0d]", tag, i),       32'(bus.a),       32'(ea[n-1-i]));
      chk($sformatf("%s done[%0d]", tag, i),    32'(bus.done),    32'(ed[n-1-i]));
      chk($sformatf("%s aborted[%0d]", tag, i), 32'(bus.aborted), 32'(eab[n-1-i]));
      chk($sformatf("%s busy[%0d]", tag, i),    32'(bus.busy),    32'(eb[n-1-i]));
      if (i == poke_on) begin
        bus.start     = 1'b1;
        bus.delay_cyc = 16'd0;
        bus.high_cyc  = 16'd1;
        bus.low_cyc   = 16'd1;
        bus.pulse_num = 8'd9;
      end
      if (i == poke_off) bus.start = 1'b0;
      if (i == stop_idx) bus.stop = 1'b1;
      if (i == stop_idx + 1) bus.stop = 1'b0;
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.delay_cyc = '0;
    bus.high_cyc  = '0;
    bus.low_cyc   = '0;
    bus.pulse_num = '0;

    #100;
    chk("reset a",         32'(bus.a),         32'd0);
    chk("reset busy",      32'(bus.busy),      32'd0);
    chk("reset done",      32'(bus.done),      32'd0);
    chk("reset aborted",   32'(bus.aborted),   32'd0);
    chk("reset pulse_cnt", 32'(bus.pulse_cnt), 32'd0);
    #100;
    rst_n = 1'b1;

    // Single pulse, no delay: high 3 cycles from the accepting edge.
    launch(0, 3, 2, 1);
    run_seq("single", 5, 32'b11100, 32'b00010, 32'b00000, 32'b11100, 99, 99, 99);
    chk("single pulse_cnt", 32'(bus.pulse_cnt), 32'd1);

    // Burst with start re-asserted and config scrambled mid-burst, start still
    // high on the edge where busy falls.
    launch(4, 2, 3, 3);
    run_seq("burst", 18, 32'b000011000110001100, 32'b000000000000000010,
            32'b0, 32'b111111111111111100, 5, 16, 99);
    chk("burst pulse_cnt", 32'(bus.pulse_cnt), 32'd3);

    // All-zero config collapses to one 1-cycle pulse.
    launch(0, 0, 0, 0);
    run_seq("zero", 3, 32'b100, 32'b010, 32'b000, 32'b100, 99, 99, 99);
    chk("zero pulse_cnt", 32'(bus.pulse_cnt), 32'd1);

    // Stop during the 4th high cycle of pulse 1.
    launch(0, 10, 2, 5);
    run_seq("abort", 6, 32'b111100, 32'b000000, 32'b000010, 32'b111100, 99, 99, 3);
    chk("abort pulse_cnt", 32'(bus.pulse_cnt), 32'd1);

    // start and stop together in IDLE: nothing happens.
    bus.stop = 1'b1;
    launch(0, 2, 2, 1);
    run_seq("startstop", 3, 32'b000, 32'b000, 32'b000, 32'b000, 99, 99, 99);
    chk("startstop pulse_cnt", 32'(bus.pulse_cnt), 32'd1);

    // Asynchronous reset in the middle of a high phase.
    launch(0, 5, 1, 2);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("prereset a",         32'(bus.a),         32'd1);
    chk("prereset pulse_cnt", 32'(bus.pulse_cnt), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async a",         32'(bus.a),         32'd0);
    chk("async busy",      32'(bus.busy),      32'd0);
    chk("async pulse_cnt", 32'(bus.pulse_cnt), 32'd0);
    chk("async done",      32'(bus.done),      32'd0);
    chk("async aborted",   32'(bus.aborted),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    launch(0, 3, 2, 1);
    run_seq("after", 5, 32'b11100, 32'b00010, 32'b00000, 32'b11100, 99, 99, 99);
    chk("after pulse_cnt", 32'(bus.pulse_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
- Programmable single/burst pulse generator; drives the level signal `a` that the edge-detection logic consumes.
- Produces a waveform with defined rising and falling edges: start delay, high width, low width, pulse count.
- Used as the on-chip stimulus/source side of the edge path, and as a reusable timed-pulse source (e.g. LED/trigger strobes).

Parameters:
- CNT_W, 16: width of the delay/high/low counters and their config inputs.
- NUM_W, 8: width of the pulse-count input and of `pulse_cnt`.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request pulse; sampled only in IDLE.
- stop, input, 1: abort; effective in any non-IDLE state.
- delay_cyc, input, CNT_W: cycles from start acceptance to first rising edge.
- high_cyc, input, CNT_W: high width in cycles; 0 is treated as 1.
- low_cyc, input, CNT_W: low width between pulses in cycles; 0 is treated as 1.
- pulse_num, input, NUM_W: pulses per burst; 0 is treated as 1.
- a, output, 1: generated waveform; registered, glitch-free.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: 1-cycle pulse when a burst completes normally.
- aborted, output, 1: 1-cycle pulse when a burst is terminated by stop.
- pulse_cnt, output, NUM_W: rising edges generated in the current or last burst.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; a=0, busy=0, done=0, aborted=0, pulse_cnt=0; all counters 0.
- Config latch: delay_cyc, high_cyc, low_cyc and pulse_num are captured on the edge that accepts start. Changes while busy have no effect.
- States: IDLE, DELAY, HIGH, LOW.
- IDLE:
  - Start is accepted at edge k when start=1 and stop=0. pulse_cnt clears to 0 at that edge.
  - If delay_cyc=0, go to HIGH.
  - Otherwise go to DELAY.
  - stop=1 and start=1 together in IDLE: stop wins, start is ignored, no aborted pulse.
- DELAY: stays exactly delay_cyc cycles, then goes to HIGH.
- HIGH:
  - a=1 for exactly high_cyc' cycles (high_cyc' = max(high_cyc,1)).
  - pulse_cnt increments on the edge entering HIGH.
  - On exit: if pulse_cnt == pulse_num' (pulse_num' = max(pulse_num,1)), go to IDLE, drop a, and assert done for 1 cycle. Otherwise go to LOW.
- LOW: a=0 for exactly low_cyc' cycles (low_cyc' = max(low_cyc,1)), then goes to HIGH.
- Timing:
  - With delay_cyc=D>0 accepted at edge k, a rises at edge k+D. With D=0, a rises at edge k.
  - Period = high_cyc' + low_cyc'.
  - No trailing LOW phase after the last pulse.
  - done asserts on the same edge a falls for the last time.
  - busy falls on that same edge.
- a is a direct register (a=1 iff state==HIGH). No combinational output decode.
- stop in DELAY, HIGH or LOW: next edge goes to IDLE, a=0, busy=0, aborted=1 for 1 cycle, done stays 0. pulse_cnt holds its value.
- start while busy is ignored; no queuing.
- Re-start is possible the cycle after done/aborted. A start at the edge where busy falls is not accepted, because the state is not yet IDLE when sampled.
- Counters use down-count from loaded value minus 1 to 0. Width CNT_W, so maximum phase length is 2^CNT_W−1 cycles; no wrap-around is possible.
- pulse_cnt saturates at 2^NUM_W−1. It cannot exceed pulse_num'.
- Reset asserted mid-burst: immediately (asynchronously) returns to IDLE with all outputs 0. No done or aborted pulse.

Test Plan:
- Reset: rst_n=0 for 200 ns, clk 20 ns period. Then start with D=0, H=3, L=2, N=1 → a high exactly 3 cycles starting at the accepting edge; done 1 cycle when a falls; pulse_cnt=1; busy high 3 cycles.
- Burst: D=4, H=2, L=3, N=3 → a rises 4 cycles after acceptance; pattern 2 high/3 low repeated, 3 rising edges; 12 cycles from first rise to last fall; done once; pulse_cnt=3.
- Zero handling: H=0, L=0, N=0, D=0 → single 1-cycle high pulse, done, pulse_cnt=1.
- Abort: D=0, H=10, N=5; stop asserted on 4th high cycle of pulse 1 → a=0 next edge; aborted=1 for 1 cycle; done never asserts; pulse_cnt=1.
- Ignore/priority:
  - start re-asserted mid-burst → no effect on waveform.
  - start+stop together in IDLE → stays IDLE, a=0, no pulses.
  - Config inputs changed mid-burst → waveform unchanged.
- Async reset mid-burst: drop rst_n during a HIGH phase (between clock edges) → a, busy, pulse_cnt go to 0 immediately. After release, next start runs normally.
